// File: rtl/pot_adc_reader_pkg.sv
// Shared widths and the frame-sequencer state encoding for the paddle ADC reader.
package pot_pkg;

  localparam int unsigned ADC_BITS   = 12;
  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned VALUE_BITS = 8;

  // Counter widths sized for the legal parameter ranges.
  localparam int unsigned BIT_CNT_W = 5;   // 0..16 rising edges
  localparam int unsigned GAP_CNT_W = 10;  // CONV_GAP up to 1023
  localparam int unsigned DIV_CNT_W = 8;   // CLK_DIV up to 255

  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT,
    LATCH,
    GAP
  } state_t;

endpackage

// File: rtl/pot_adc_reader_if.sv
// Pmod ADC serial pins plus the filtered position bus presented to game logic.
interface pot_adc_reader_if;
  import pot_pkg::*;

  logic                  cs_n;
  logic                  sclk;
  logic                  sdata;
  logic [ADC_BITS-1:0]   adc_raw;
  logic [VALUE_BITS-1:0] value;
  logic                  value_valid;

  // Reader side: drives the ADC control lines and the position outputs.
  modport master (
    output cs_n, sclk, adc_raw, value, value_valid,
    input  sdata
  );

  // ADC / consumer side.
  modport slave (
    input  cs_n, sclk, adc_raw, value, value_valid,
    output sdata
  );

endinterface

// File: rtl/pot_adc_reader_sclk_divider.sv
// SCLK generator: divides sys_clk by CLK_DIV per half-period, idles high while cleared.
// The rise flag is combinational: it is high in the cycle whose edge drives sclk high.
module sclk_divider
  import pot_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic clr,
  output logic sclk,
  output logic rise
);

  logic [DIV_CNT_W-1:0] div_cnt_q;
  logic                 sclk_q;
  logic                 toggle_c;

  assign toggle_c = !clr && (div_cnt_q == DIV_CNT_W'(CLK_DIV - 1));
  assign rise     = toggle_c && !sclk_q;
  assign sclk     = sclk_q;

  // Divider count and sclk toggle; reset forces sclk high immediately.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
      sclk_q    <= 1'b1;
    end else if (clr) begin
      div_cnt_q <= '0;
      sclk_q    <= 1'b1;
    end else if (toggle_c) begin
      div_cnt_q <= '0;
      sclk_q    <= !sclk_q;
    end else begin
      div_cnt_q <= div_cnt_q + DIV_CNT_W'(1);
    end
  end

endmodule

// File: rtl/pot_adc_reader.sv
// Paddle potentiometer reader: frames the Pmod ADC serial transfer, keeps the
// 12 data bits of each 16-bit frame and presents an 8-bit position.
// Build option POT_AVG_EN: box-average 2^AVG_LOG2 samples before updating value.
module pot_adc_reader
  import pot_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned CONV_GAP = 16,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic              sys_clk,
  input  logic              reset,
  pot_adc_reader_if.master  bus
);

  if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("CLK_DIV out of range 1..255");
  end
  if (CONV_GAP < 1 || CONV_GAP > 1023) begin : g_bad_conv_gap
    $error("CONV_GAP out of range 1..1023");
  end
  if (AVG_LOG2 > 4) begin : g_bad_avg_log2
    $error("AVG_LOG2 out of range 0..4");
  end

  state_t                state_q, state_d;
  logic [ADC_BITS-1:0]   shift_q;
  logic [BIT_CNT_W-1:0]  bit_cnt_q;
  logic [GAP_CNT_W-1:0]  gap_cnt_q;
  logic                  cs_n_q;
  logic [ADC_BITS-1:0]   adc_raw_q;
  logic [VALUE_BITS-1:0] value_q;
  logic                  value_valid_q;
  logic                  done_q;

  logic start_c, shift_c, latch_c, gap_c;
  logic sclk, rise;

  sclk_divider #(.CLK_DIV(CLK_DIV)) u_sclk_divider (
    .sys_clk (sys_clk),
    .reset   (reset),
    .clr     (!shift_c),
    .sclk    (sclk),
    .rise    (rise)
  );

  // State register.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: one frame is START, 16 sclk periods of SHIFT, LATCH, then the gap.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  state_d = START;
      START: state_d = SHIFT;
      SHIFT: if (rise && bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1)) state_d = LATCH;
      LATCH: state_d = GAP;
      GAP:   if (gap_cnt_q == GAP_CNT_W'(CONV_GAP)) state_d = START;
      default: state_d = IDLE;
    endcase
  end

  // Per-state control strobes.
  always_comb begin
    start_c = 1'b0;
    shift_c = 1'b0;
    latch_c = 1'b0;
    gap_c   = 1'b0;
    unique case (state_q)
      START:   start_c = 1'b1;
      SHIFT:   shift_c = 1'b1;
      LATCH:   latch_c = 1'b1;
      GAP:     gap_c   = 1'b1;
      default: ;
    endcase
  end

  // Frame datapath; the shift register only keeps 12 bits so the leading nibble falls off.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      cs_n_q    <= 1'b1;
      adc_raw_q <= '0;
    end else begin
      if (start_c) begin
        shift_q   <= '0;
        bit_cnt_q <= '0;
        cs_n_q    <= 1'b0;
      end else if (rise) begin
        shift_q   <= {shift_q[ADC_BITS-2:0], bus.sdata};
        bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
      end
      if (latch_c) begin
        cs_n_q    <= 1'b1;
        adc_raw_q <= shift_q;
      end
    end
  end

  // Gap timer: cleared outside GAP, exits the gap when it reaches CONV_GAP.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset)      gap_cnt_q <= '0;
    else if (gap_c) gap_cnt_q <= gap_cnt_q + GAP_CNT_W'(1);
    else            gap_cnt_q <= '0;
  end

`ifdef POT_AVG_EN
  localparam int unsigned ACC_W = ADC_BITS + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2 + 1;

  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;

  // Box filter: accumulate each LATCH, publish the truncated mean the cycle after a full window.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      acc_q         <= '0;
      cnt_q         <= '0;
      done_q        <= 1'b0;
      value_q       <= '0;
      value_valid_q <= 1'b0;
    end else begin
      value_valid_q <= done_q;
      done_q        <= latch_c && ((cnt_q + CNT_W'(1)) == CNT_W'(1 << AVG_LOG2));
      if (done_q) begin
        value_q <= VALUE_BITS'(acc_q >> (AVG_LOG2 + ADC_BITS - VALUE_BITS));
        acc_q   <= '0;
        cnt_q   <= '0;
      end else if (latch_c) begin
        acc_q <= acc_q + ACC_W'(shift_q);
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end
`else
  // Unfiltered: every LATCH publishes the top bits of the new sample on the next cycle.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      done_q        <= 1'b0;
      value_q       <= '0;
      value_valid_q <= 1'b0;
    end else begin
      done_q        <= latch_c;
      value_valid_q <= done_q;
      if (done_q) value_q <= VALUE_BITS'(adc_raw_q >> (ADC_BITS - VALUE_BITS));
    end
  end
`endif

  assign bus.cs_n        = cs_n_q;
  assign bus.sclk        = sclk;
  assign bus.adc_raw     = adc_raw_q;
  assign bus.value       = value_q;
  assign bus.value_valid = value_valid_q;

endmodule

// File: tb/tb_pot_adc_reader.sv
// Bench for pot_adc_reader: an ADC model serves frames chosen per phase, and a
// window-average reference model predicts adc_raw, value and the value_valid strobe.
module tb_pot_adc_reader;

  localparam int unsigned CLK_DIV  = 2;
  localparam int unsigned CONV_GAP = 16;
  localparam int unsigned AVG_LOG2 = 2;
  localparam int PERIOD  = 32 * CLK_DIV + 3 + CONV_GAP;
  localparam int CS_LOW  = 32 * CLK_DIV + 1;
`ifdef POT_AVG_EN
  localparam int WIN = 1 << AVG_LOG2;
`else
  localparam int WIN = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;

  pot_adc_reader_if bus ();

  pot_adc_reader #(
    .CLK_DIV  (CLK_DIV),
    .CONV_GAP (CONV_GAP),
    .AVG_LOG2 (AVG_LOG2)
  ) dut (
    .sys_clk (clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk = !clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stimulus selection and ADC model state.
  int mode = 0;
  int phase_idx = 0;
  logic [15:0] cur_word = '0;
  int bit_idx = -1;

  function automatic logic [15:0] gen_word(input int m, input int idx);
    logic [15:0] w;
    case (m)
      0:       w = 16'h0ABC;
      1:       w = (idx % 2 == 0) ? 16'h0100 : 16'h0300;
      2:       w = 16'hF000;
      3:       w = {4'($urandom), 12'hFFF};
      5:       w = 16'h05A3;
      default: w = 16'($urandom);
    endcase
    return w;
  endfunction

  // ADC serial output: next bit presented on each sclk fall, MSB first.
  always @(negedge bus.sclk) begin
    if (!bus.cs_n && bit_idx >= 0) begin
      bus.sdata = cur_word[bit_idx];
      bit_idx--;
    end
  end

  // Monitor and reference model, sampled 1 time unit after each rising edge.
  int cyc = 0;
  int latch_total = 0;
  int rise_in_frame = 0;
  int low_cnt = 0;
  int exp_valid_at = -1;
  int frames_since_reset = 0;
  int last_fall_cyc = 0;
  logic prev_cs_n = 1'b1;
  logic prev_sclk = 1'b1;
  logic frame_active = 1'b0;
  logic [11:0] sent = '0;
  int unsigned win_sum = 0;
  int win_n = 0;
  logic [7:0] exp_value = '0;
  logic [7:0] pend_value = '0;

  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (reset) begin
      win_sum = 0;
      win_n = 0;
      exp_valid_at = -1;
      exp_value = '0;
      frame_active = 1'b0;
      frames_since_reset = 0;
    end else begin
      if (prev_cs_n && !bus.cs_n) begin
        cur_word = gen_word(mode, phase_idx);
        phase_idx++;
        bit_idx = 15;
        sent = cur_word[11:0];
        low_cnt = 0;
        rise_in_frame = 0;
        frame_active = 1'b1;
        if (frames_since_reset > 0) chk("frame_period", 32'(cyc - last_fall_cyc), 32'(PERIOD));
        last_fall_cyc = cyc;
        frames_since_reset++;
      end
      if (!bus.cs_n) low_cnt++;
      if (!prev_sclk && bus.sclk && !bus.cs_n) rise_in_frame++;
      if (!prev_cs_n && bus.cs_n && frame_active) begin
        frame_active = 1'b0;
        latch_total++;
        chk("cs_low_cycles", 32'(low_cnt), 32'(CS_LOW));
        chk("sclk_rises", 32'(rise_in_frame), 32'd16);
        chk("adc_raw", 32'(bus.adc_raw), 32'(sent));
        chk("value_hold", 32'(bus.value), 32'(exp_value));
        win_sum += sent;
        win_n++;
        if (win_n == WIN) begin
          pend_value = 8'((win_sum / WIN) / 16);
          exp_valid_at = cyc + 1;
          win_sum = 0;
          win_n = 0;
        end
      end
      if (bus.value_valid || cyc == exp_valid_at) begin
        chk("value_valid", 32'(bus.value_valid), 32'(cyc == exp_valid_at));
        if (cyc == exp_valid_at) begin
          exp_value = pend_value;
          chk("value", 32'(bus.value), 32'(exp_value));
        end
      end
    end
    prev_cs_n = bus.cs_n;
    prev_sclk = bus.sclk;
  end

  task automatic wait_frames(input int n);
    int start;
    bit done;
    start = latch_total;
    done = 0;
    for (int i = 0; i < n * PERIOD + 200; i++) begin
      @(posedge clk);
      if (latch_total - start >= n) begin
        done = 1;
        break;
      end
    end
    chk("wait_frames", 32'(done), 32'd1);
  endtask

  task automatic wait_rises(input int n);
    bit done;
    done = 0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      @(posedge clk);
      #2;
      if (!bus.cs_n && rise_in_frame >= n) begin
        done = 1;
        break;
      end
    end
    chk("wait_rises", 32'(done), 32'd1);
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic new_phase(input int m);
    mode = m;
    phase_idx = 0;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sdata = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", 32'(bus.cs_n), 32'd1);
    chk("rst_sclk", 32'(bus.sclk), 32'd1);
    chk("rst_adc_raw", 32'(bus.adc_raw), 32'd0);
    chk("rst_value", 32'(bus.value), 32'd0);
    chk("rst_value_valid", 32'(bus.value_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    new_phase(0);
    wait_frames(4);
    settle();
    chk("abc_adc_raw", 32'(bus.adc_raw), 32'h0ABC);
    chk("abc_value", 32'(bus.value), 32'hAB);

    new_phase(1);
    wait_frames(8);
    settle();
`ifdef POT_AVG_EN
    chk("alt_value", 32'(bus.value), 32'h20);
`else
    chk("alt_value", 32'(bus.value), 32'h30);
`endif

    new_phase(2);
    wait_frames(4);
    settle();
    chk("nibble_adc_raw", 32'(bus.adc_raw), 32'h000);
    chk("nibble_value", 32'(bus.value), 32'h00);

    new_phase(3);
    wait_frames(4);
    settle();
    chk("full_value", 32'(bus.value), 32'hFF);

    new_phase(4);
    wait_frames(12);

    // Reset during bit 7 of the second frame from here; cs_n/sclk must rise without a clock edge.
    wait_frames(1);
    wait_rises(7);
    #1;
    chk("pre_rst_cs_n", 32'(bus.cs_n), 32'd0);
    reset = 1'b1;
    #1;
    chk("async_cs_n", 32'(bus.cs_n), 32'd1);
    chk("async_sclk", 32'(bus.sclk), 32'd1);
    chk("async_value", 32'(bus.value), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    new_phase(4);
    wait_frames(8);

    new_phase(5);
    wait_frames(4);
    settle();
    chk("5a3_adc_raw", 32'(bus.adc_raw), 32'h5A3);
    chk("5a3_value", 32'(bus.value), 32'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
